status_value_drain: RTL

- Reader/consumer end of the status value vector, a shift queue with its head at entry [0] and push/pull control.
- Watches the vector head and generates the pull_o strobe that pops it.
- Registers each popped value into a one-entry output stage with a valid/ready handshake toward downstream logic.
- Also provides a flush mode that discards all queued entries, and delivered/discarded counters.

---
 rtl/status_value_pkg.sv | 25 ++
 rtl/status_value_out_reg.sv | 45 ++++
 rtl/status_value_drain.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/status_value_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : status_value_pkg
//  Description : Shared definitions for the status value vector and its
//                drain/consumer logic: state encoding of the drain FSM and
//                the default entry/counter widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package status_value_pkg;

    localparam int c_default_width = 8;
    localparam int c_default_cnt_w = 8;

    localparam logic [1:0] c_st_run   = 2'd0;
    localparam logic [1:0] c_st_flush = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    typedef enum logic [1:0] {
        RUN   = c_st_run,
        FLUSH = c_st_flush,
        DONE  = c_st_done
    } state_t;

endpackage : status_value_pkg
`default_nettype wire

// File: rtl/status_value_out_reg.sv
`default_nettype none
// ============================================================================
//  Module      : status_value_out_reg
//  Description : One-entry output stage with valid flag. A load captures a
//                new value and sets valid; a clear drops valid. Load wins
//                over clear so a transfer and a refill can share one edge.
//  Ports       : clk_i, arst_i        clock, async active-high reset
//                load_i, load_value_i capture a new value
//                clear_i              drop valid (transfer or discard)
//                value_o, valid_o     held entry
//  Revision    : 1.0 - initial release
// ============================================================================
module status_value_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] value_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] r_value;
    logic             r_valid;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_value <= '0;
            r_valid <= 1'b0;
        end else if (load_i) begin
            r_value <= load_value_i;
            r_valid <= 1'b1;
        end else if (clear_i) begin
            // value is kept; only the valid flag drops
            r_valid <= 1'b0;
        end
    end

    assign value_o = r_value;
    assign valid_o = r_valid;

endmodule : status_value_out_reg
`default_nettype wire

// File: rtl/status_value_drain.sv
`default_nettype none
// ============================================================================
//  Module      : status_value_drain
//  Description : Consumer end of the status value shift vector. Pops the
//                vector head into a one-entry valid/ready output stage and
//                supports a flush mode that discards every queued entry
//                (including ones pushed while flushing).
//  Ports       : clk_i, arst_i                  clock, async reset
//                head_value_i, head_valid_i     vector entry [0]
//                pull_o                         pop strobe for entry [0]
//                enable_i                       allow pulls in RUN
//                flush_i                        flush request
//                out_value_o/out_valid_o/out_ready_i  downstream handshake
//                busy_o, flush_done_o           flush status
//                rd_cnt_o, flush_cnt_o          delivered / discarded counts
//  Revision    : 1.0 - initial release
// ============================================================================
module status_value_drain
    import status_value_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int CNT_W = c_default_cnt_w
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic [WIDTH-1:0] head_value_i,
    input  logic             head_valid_i,
    output logic             pull_o,
    input  logic             enable_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] out_value_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic             flush_done_o,
    output logic [CNT_W-1:0] rd_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_rd_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_out_valid;
    logic             w_xfer;
    logic             w_pull;
    logic             w_load;
    logic             w_clear;
    logic             w_flush_enter;
    logic             w_discard;

    assign w_xfer = w_out_valid & out_ready_i;

    // A held entry that is not leaving on the flush-entry edge is thrown away
    // and becomes the first counted discard.
    assign w_discard = w_out_valid & ~out_ready_i;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pull        = 1'b0;
        w_load        = 1'b0;
        w_clear       = 1'b0;
        w_flush_enter = 1'b0;
        case (r_state)
            RUN: begin
                w_pull = enable_i & head_valid_i & (~w_out_valid | out_ready_i) & ~flush_i;
                w_load = w_pull;
                if (flush_i) begin
                    w_state_nxt   = FLUSH;
                    w_clear       = 1'b1;
                    w_flush_enter = 1'b1;
                end else begin
                    w_clear = w_xfer;
                end
            end
            FLUSH: begin
                // Keep popping until an empty head is actually observed, so
                // late pushes are discarded too.
                w_pull = head_valid_i;
                if (!head_valid_i) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_rd_cnt    <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_xfer) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            if (w_flush_enter) begin
                r_flush_cnt <= {{(CNT_W-1){1'b0}}, w_discard};
            end else if ((r_state == FLUSH) && w_pull && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    status_value_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk_i        (clk_i),
        .arst_i       (arst_i),
        .load_i       (w_load),
        .load_value_i (head_value_i),
        .clear_i      (w_clear),
        .value_o      (out_value_o),
        .valid_o      (w_out_valid)
    );

    // The state register is already RUN during reset, but the pull term is
    // combinational on live inputs, so it is gated by reset explicitly.
    assign pull_o       = w_pull & ~arst_i;
    assign out_valid_o  = w_out_valid;
    assign busy_o       = (r_state != RUN);
    assign flush_done_o = (r_state == DONE);
    assign rd_cnt_o     = r_rd_cnt;
    assign flush_cnt_o  = r_flush_cnt;

endmodule : status_value_drain
`default_nettype wire
